// File: rtl/conv_pe_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_stream
// Description : Convolution PE - signed tap MAC with saturating accumulator,
//               requantisation (shift/ReLU/clamp) and packed result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pe_stream #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int KSIZE     = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_wr,
    input  logic [$clog2(KSIZE)-1:0]      w_addr,
    input  logic [DATA_W-1:0]             w_data,
    input  logic                          start,
    input  logic [$clog2(KSIZE+1)-1:0]    cfg_taps,
    input  logic [15:0]                   cfg_outputs,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cfg_relu,
    output logic                          cfg_err,
    output logic                          busy,
    input  logic                          act_valid,
    input  logic [DATA_W-1:0]             act_data,
    output logic                          act_ready,
    output logic                          out_valid,
    output logic [DATA_W*OUT_DEPTH-1:0]   out_data,
    input  logic                          out_ready,
    output logic [$clog2(OUT_DEPTH+1)-1:0] out_count,
    output logic                          done
);

    localparam int TAP_W  = $clog2(KSIZE);
    localparam int CNT_W  = $clog2(KSIZE+1);
    localparam int SLOT_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCNT_W = $clog2(OUT_DEPTH+1);
    localparam int PROD_W = 2*DATA_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic signed [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] C_RES_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_RES_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [2:0]                  r_state;
    logic [2:0]                  w_next_state;
    logic signed [DATA_W-1:0]    r_weights [KSIZE];
    logic [CNT_W-1:0]            r_taps;
    logic [15:0]                 r_outputs;
    logic [4:0]                  r_shift;
    logic                        r_relu;
    logic signed [ACC_W-1:0]     r_acc;
    logic                        r_sat;
    logic [TAP_W-1:0]            r_tap_idx;
    logic [SLOT_W-1:0]           r_slot_idx;
    logic [15:0]                 r_out_cnt;
    logic [DATA_W*OUT_DEPTH-1:0] r_out_data;
    logic                        r_cfg_err;

    logic                        w_cfg_ok;
    logic                        w_start_ok;
    logic                        w_accept;
    logic                        w_last_tap;
    logic                        w_word_full;
    logic                        w_last_output;
    logic                        w_all_done;
    logic signed [DATA_W-1:0]    w_act;
    logic signed [DATA_W-1:0]    w_weight;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_W:0]       w_sum;
    logic                        w_ovf;
    logic signed [ACC_W-1:0]     w_acc_next;
    logic signed [ACC_W-1:0]     w_shifted;
    logic signed [ACC_W-1:0]     w_res_wide;
    logic [DATA_W-1:0]           w_res;

    assign w_cfg_ok      = (cfg_taps != '0) && (cfg_taps <= CNT_W'(KSIZE)) && (cfg_outputs != 16'd0);
    assign w_start_ok    = (r_state == S_IDLE) && start && w_cfg_ok;
    assign w_accept      = (r_state == S_RUN) && act_valid;
    assign w_last_tap    = (CNT_W'(r_tap_idx) == (r_taps - CNT_W'(1)));
    assign w_word_full   = (r_slot_idx == SLOT_W'(OUT_DEPTH-1));
    assign w_last_output = ((r_out_cnt + 16'd1) == r_outputs);
    assign w_all_done    = (r_out_cnt == r_outputs);

    // MAC with overflow detected in one extra bit; once saturated the value holds until WRITE.
    assign w_act    = $signed(act_data);
    assign w_weight = r_weights[r_tap_idx];
    assign w_prod   = w_act * w_weight;
    assign w_sum    = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_ovf    = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (r_sat) begin
            w_acc_next = r_acc;
        end else if (w_ovf) begin
            w_acc_next = w_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX;
        end
    end

    assign w_shifted = r_acc >>> r_shift;

    always_comb begin
        w_res_wide = w_shifted;
        if (r_relu && w_shifted[ACC_W-1]) begin
            w_res_wide = '0;
        end
        if (w_res_wide > C_RES_MAX) begin
            w_res_wide = C_RES_MAX;
        end else if (w_res_wide < C_RES_MIN) begin
            w_res_wide = C_RES_MIN;
        end
    end

    assign w_res = w_res_wide[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next_state = S_RUN;
            S_RUN:   if (w_accept && w_last_tap) w_next_state = S_WRITE;
            S_WRITE: w_next_state = (w_word_full || w_last_output) ? S_FLUSH : S_RUN;
            S_FLUSH: if (out_ready) w_next_state = w_all_done ? S_DONE : S_RUN;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        act_ready = (r_state == S_RUN);
        out_valid = (r_state == S_FLUSH);
        done      = (r_state == S_DONE);
        out_count = '0;
        if (r_state == S_FLUSH) begin
            out_count = OCNT_W'(r_slot_idx) + OCNT_W'(1);
        end
    end

    assign out_data = r_out_data;
    assign cfg_err  = r_cfg_err;

    // Weight storage deliberately has no reset so taps survive an aborted run.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && w_wr) begin
            r_weights[w_addr] <= $signed(w_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_taps     <= '0;
            r_outputs  <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_tap_idx  <= '0;
            r_slot_idx <= '0;
            r_out_cnt  <= '0;
            r_out_data <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == S_IDLE) && start && !w_cfg_ok;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_taps     <= cfg_taps;
                        r_outputs  <= cfg_outputs;
                        r_shift    <= cfg_shift;
                        r_relu     <= cfg_relu;
                        r_acc      <= '0;
                        r_sat      <= 1'b0;
                        r_tap_idx  <= '0;
                        r_slot_idx <= '0;
                        r_out_cnt  <= '0;
                        r_out_data <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_acc     <= w_acc_next;
                        r_sat     <= r_sat | w_ovf;
                        r_tap_idx <= w_last_tap ? '0 : r_tap_idx + TAP_W'(1);
                    end
                end
                S_WRITE: begin
                    r_out_data[int'(r_slot_idx)*DATA_W +: DATA_W] <= w_res;
                    r_acc     <= '0;
                    r_sat     <= 1'b0;
                    r_out_cnt <= r_out_cnt + 16'd1;
                    if (!(w_word_full || w_last_output)) begin
                        r_slot_idx <= r_slot_idx + SLOT_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (out_ready) begin
                        r_slot_idx <= '0;
                        r_out_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_pe_stream
// Description : Directed self-checking bench for conv_pe_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_pe_stream;

    logic        clk;
    logic        rst;
    logic        w_wr;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic        start;
    logic [4:0]  cfg_taps;
    logic [15:0] cfg_outputs;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic        cfg_err;
    logic        busy;
    logic        act_valid;
    logic [7:0]  act_data;
    logic        act_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  out_count;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    conv_pe_stream #(.DATA_W(8), .ACC_W(24), .KSIZE(16), .OUT_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
        .start(start), .cfg_taps(cfg_taps), .cfg_outputs(cfg_outputs),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_err(cfg_err), .busy(busy),
        .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_count(out_count), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic write_w(input logic [3:0] a, input logic [7:0] d);
        wait_idle();
        w_wr = 1'b1; w_addr = a; w_data = d;
        step();
        w_wr = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] taps, input logic [15:0] outs,
                             input logic [4:0] sh, input logic relu);
        wait_idle();
        start = 1'b1; cfg_taps = taps; cfg_outputs = outs; cfg_shift = sh; cfg_relu = relu;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] a);
        int n = 0;
        act_valid = 1'b1; act_data = a;
        while (!act_ready && n < 50) begin
            step();
            n++;
        end
        step();
        act_valid = 1'b0;
    endtask

    task automatic wait_word(output logic [31:0] d, output logic [2:0] c, output bit to);
        int n = 0;
        to = 1'b0; d = '0; c = '0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        if (!out_valid) begin
            to = 1'b1;
        end else begin
            d = out_data; c = out_count;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        n_checks++;
        if ({busy, act_ready, out_valid, done, cfg_err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags got=%b exp=00000", {busy, act_ready, out_valid, done, cfg_err});
        end
        n_checks++;
        if (out_data !== 32'h0 || out_count !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_data got=%h/%0d exp=0/0", out_data, out_count);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [2:0] c; bit to;
        for (int i = 0; i < 4; i++) write_w(4'(i), 8'(i + 1));
        start_run(5'd4, 16'd4, 5'd0, 1'b0);
        for (int i = 0; i < 16; i++) feed(8'd1);
        wait_word(d, c, to);
        n_checks++;
        if (to || d !== 32'h0A0A0A0A || c !== 3'd4) begin
            n_errors++;
            $display("FAIL t1_word got=%h/%0d to=%0d exp=0a0a0a0a/4", d, c, to);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL t1_done got=%b%b exp=11", done, busy);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL t1_idle got=%b%b exp=00", done, busy);
        end
    endtask

    task automatic test_requant();
        logic [31:0] d; logic [2:0] c; bit to;
        logic [7:0]  w0 [5];
        logic [7:0]  a0 [5];
        logic [7:0]  a1 [5];
        logic        rl [5];
        logic [4:0]  sh [5];
        logic [31:0] ex [5];
        w0 = '{8'd127, 8'h80, 8'h80, 8'd100, 8'd100};
        a0 = '{8'd127, 8'd127, 8'd127, 8'd100, 8'h9C};
        a1 = '{8'd127, 8'd127, 8'd127, 8'd50,  8'hCE};
        rl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        sh = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7};
        ex = '{32'h7F, 32'h00, 32'h80, 32'h75, 32'h8A};
        for (int k = 0; k < 5; k++) begin
            write_w(4'd0, w0[k]);
            write_w(4'd1, w0[k]);
            start_run(5'd2, 16'd1, sh[k], rl[k]);
            feed(a0[k]);
            feed(a1[k]);
            wait_word(d, c, to);
            n_checks++;
            if (to || d !== ex[k] || c !== 3'd1) begin
                n_errors++;
                $display("FAIL t2_requant%0d got=%h/%0d exp=%h/1", k, d, c, ex[k]);
            end
        end
    endtask

    task automatic test_multiword();
        logic [31:0] d; logic [2:0] c; bit to;
        write_w(4'd0, 8'd3);
        start_run(5'd1, 16'd6, 5'd0, 1'b0);
        for (int i = 1; i <= 4; i++) feed(8'(i));
        wait_word(d, c, to);
        n_checks++;
        if (to || d !== 32'h0C090603 || c !== 3'd4) begin
            n_errors++;
            $display("FAIL t3_word0 got=%h/%0d exp=0c090603/4", d, c);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL t3_mid_done got=%b%b exp=01", done, busy);
        end
        feed(8'd5);
        feed(8'd6);
        wait_word(d, c, to);
        n_checks++;
        if (to || d !== 32'h0000120F || c !== 3'd2) begin
            n_errors++;
            $display("FAIL t3_word1 got=%h/%0d exp=0000120f/2", d, c);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL t3_done got=%b exp=1", done);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [2:0] c; bit to;
        logic [7:0] acts [8];
        int n;
        acts = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 0; i < 4; i++) write_w(4'(i), 8'(i + 1));
        start_run(5'd4, 16'd2, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) feed(acts[i]);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        act_valid = 1'b1; act_data = 8'd99;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || act_ready !== 1'b0 || out_data !== 32'h0000141E || out_count !== 3'd2) begin
                n_errors++;
                $display("FAIL t4_hold%0d got=%b%b %h/%0d exp=10 0000141e/2", i, out_valid, act_ready, out_data, out_count);
            end
            step();
        end
        act_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL t4_done got=%b exp=1", done);
        end
        start_run(5'd4, 16'd2, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) step();
            feed(acts[i]);
        end
        wait_word(d, c, to);
        n_checks++;
        if (to || d !== 32'h0000141E || c !== 3'd2) begin
            n_errors++;
            $display("FAIL t4_gaps got=%h/%0d exp=0000141e/2", d, c);
        end
    endtask

    task automatic test_cfg_err();
        logic [4:0]  tp [3];
        logic [15:0] op [3];
        tp = '{5'd0, 5'd17, 5'd4};
        op = '{16'd1, 16'd1, 16'd0};
        for (int k = 0; k < 3; k++) begin
            start_run(tp[k], op[k], 5'd0, 1'b0);
            n_checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL t5_err%0d got=%b%b exp=10", k, cfg_err, busy);
            end
            step();
            n_checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL t5_clear%0d got=%b%b exp=00", k, cfg_err, busy);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d; logic [2:0] c; bit to;
        start_run(5'd4, 16'd4, 5'd0, 1'b0);
        feed(8'd1);
        feed(8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({busy, act_ready, out_valid, done} !== 4'b0 || out_data !== 32'h0 || out_count !== 3'd0) begin
            n_errors++;
            $display("FAIL t6_abort got=%b %h/%0d exp=0000 0/0", {busy, act_ready, out_valid, done}, out_data, out_count);
        end
        start_run(5'd4, 16'd4, 5'd0, 1'b0);
        for (int i = 0; i < 16; i++) feed(8'd1);
        wait_word(d, c, to);
        n_checks++;
        if (to || d !== 32'h0A0A0A0A || c !== 3'd4 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL t6_rerun got=%h/%0d done=%b exp=0a0a0a0a/4 1", d, c, done);
        end
    endtask

    initial begin
        rst = 1'b1; w_wr = 1'b0; w_addr = '0; w_data = '0; start = 1'b0;
        cfg_taps = '0; cfg_outputs = '0; cfg_shift = '0; cfg_relu = 1'b0;
        act_valid = 1'b0; act_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_requant();
        test_multiword();
        test_backpressure();
        test_cfg_err();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
